// File: rtl/demorgan_pkg.sv
// Shared definitions for the demorgan sweep/check stage.
//   state_t        : sweep FSM states
//   RSP_*          : bit positions inside the 8-bit response bus
//   MSK_*          : bit positions inside the 6-bit mismatch mask
package demorgan_pkg;

    localparam int unsigned RSP_W  = 8;
    localparam int unsigned MASK_W = 6;
    localparam int unsigned VEC_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Response bus layout: {npAandB, nAornB, npAorB, nAandnB, AandB, AorB, nB, nA}
    localparam int unsigned RSP_NA     = 0;
    localparam int unsigned RSP_NB     = 1;
    localparam int unsigned RSP_AORB   = 2;
    localparam int unsigned RSP_AANDB  = 3;
    localparam int unsigned RSP_NANDNB = 4;
    localparam int unsigned RSP_NPAORB = 5;
    localparam int unsigned RSP_NAORNB = 6;
    localparam int unsigned RSP_NPANDB = 7;

    // Mismatch mask layout; NOR and NAND bits each cover both De Morgan forms
    localparam int unsigned MSK_NA   = 0;
    localparam int unsigned MSK_NB   = 1;
    localparam int unsigned MSK_OR   = 2;
    localparam int unsigned MSK_AND  = 3;
    localparam int unsigned MSK_NOR  = 4;
    localparam int unsigned MSK_NAND = 5;

endpackage

// File: rtl/demorgan_expect.sv
// Combinational checker: compares a response word against the values the
// De Morgan identities require for the driven a/b.
//   i_a, i_b   : inputs that were driven into the checked block
//   i_rsp      : response word from the checked block
//   o_mask_c   : per-function mismatch mask (1 = wrong)
module demorgan_expect
    import demorgan_pkg::*;
(
    input  logic              i_a,
    input  logic              i_b,
    input  logic [RSP_W-1:0]  i_rsp,
    output logic [MASK_W-1:0] o_mask_c
);

    logic w_nor;
    logic w_nand;

    assign w_nor  = ~(i_a | i_b);
    assign w_nand = ~(i_a & i_b);

    always_comb begin
        o_mask_c           = '0;
        o_mask_c[MSK_NA]   = i_rsp[RSP_NA]    != ~i_a;
        o_mask_c[MSK_NB]   = i_rsp[RSP_NB]    != ~i_b;
        o_mask_c[MSK_OR]   = i_rsp[RSP_AORB]  != (i_a | i_b);
        o_mask_c[MSK_AND]  = i_rsp[RSP_AANDB] != (i_a & i_b);
        // ~a & ~b and ~(a|b) must both equal NOR
        o_mask_c[MSK_NOR]  = (i_rsp[RSP_NANDNB] != w_nor)  | (i_rsp[RSP_NPAORB] != w_nor);
        // ~a | ~b and ~(a&b) must both equal NAND
        o_mask_c[MSK_NAND] = (i_rsp[RSP_NAORNB] != w_nand) | (i_rsp[RSP_NPANDB] != w_nand);
    end

endmodule

// File: rtl/demorgan_sweep.sv
// Stimulus and result-checking stage for the demorgan gate block. A start
// pulse sweeps {A,B} through 00,01,10,11 PASSES times, holding each vector
// SETTLE_CYCLES cycles, then samples and checks the eight returned outputs.
//   clk, reset          : clock, asynchronous active-high reset
//   start               : single-cycle run request (ignored while busy)
//   dut_a, dut_b        : registered drive into the checked block
//   rsp                 : checked block outputs, bit 0 = nA
//   busy, done, pass    : run status; pass valid while done
//   err_count           : saturating count of failing vector checks
//   fail_vec, fail_mask : vector and mismatch mask of the first failure
module demorgan_sweep
    import demorgan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              dut_a,
    output logic              dut_b,
    input  logic [RSP_W-1:0]  rsp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [VEC_W-1:0]  fail_vec,
    output logic [MASK_W-1:0] fail_mask
);

    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned PAS_W = $clog2(PASSES + 1);

    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [PAS_W-1:0] PAS_DONE = PAS_W'(PASSES);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t             r_state;
    logic [VEC_W-1:0]   r_vec;
    logic [SET_W-1:0]   r_settle;
    logic [PAS_W-1:0]   r_pass_cnt;
    logic [RSP_W-1:0]   r_rsp;

    logic [MASK_W-1:0]  w_mask;
    logic [ERR_W-1:0]   w_err_next;
    logic [PAS_W-1:0]   w_pass_inc;
    logic               w_fail;

    // Drive straight from the vector register so the pins never glitch
    assign dut_a = r_vec[1];
    assign dut_b = r_vec[0];

    demorgan_expect u_expect (
        .i_a      (r_vec[1]),
        .i_b      (r_vec[0]),
        .i_rsp    (r_rsp),
        .o_mask_c (w_mask)
    );

    assign w_fail     = (w_mask != '0);
    assign w_pass_inc = r_pass_cnt + PAS_W'(1);

    // Saturating error count as it will be after the current check
    always_comb begin
        w_err_next = err_count;
        if (w_fail && (err_count != ERR_MAX)) begin
            w_err_next = err_count + ERR_W'(1);
        end
    end

    // Sweep FSM with registered status/result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_vec      <= '0;
            r_settle   <= '0;
            r_pass_cnt <= '0;
            r_rsp      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
            fail_mask  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        err_count  <= '0;
                        fail_vec   <= '0;
                        fail_mask  <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        r_vec      <= '0;
                        r_settle   <= '0;
                        r_pass_cnt <= '0;
                        r_state    <= ST_DRIVE;
                    end
                end

                ST_DRIVE: begin
                    if (r_settle == SET_LAST) begin
                        r_settle <= '0;
                        r_state  <= ST_SAMPLE;
                    end else begin
                        r_settle <= r_settle + SET_W'(1);
                    end
                end

                ST_SAMPLE: begin
                    r_rsp   <= rsp;
                    r_state <= ST_CHECK;
                end

                ST_CHECK: begin
                    err_count <= w_err_next;
                    // err_count is only zero before the first failure of a run
                    if (w_fail && (err_count == '0)) begin
                        fail_vec  <= r_vec;
                        fail_mask <= w_mask;
                    end
                    r_vec <= r_vec + VEC_W'(1);
                    if (r_vec == '1) begin
                        r_pass_cnt <= w_pass_inc;
                        if (w_pass_inc == PAS_DONE) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (w_err_next == '0);
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_DRIVE;
                        end
                    end else begin
                        r_state <= ST_DRIVE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
